// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice: FSM state,
// register-file constants and the ID/EXE control-field layout.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control-field widths carried in ID/EXE; idexe_bubble zeroes all three groups.
    localparam int CTRL_WB_W  = 2;
    localparam int CTRL_M_W   = 3;
    localparam int CTRL_EXE_W = 4;

    localparam int M_MEM_READ_BIT = 1;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the EXE load writes a register that the ID
// instruction reads, so ID must wait one cycle for the loaded data.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_exe_mem_read,
    input  logic [4:0] i_exe_dest,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_exe_dest == i_id_rs);
    assign w_rt_hit = i_id_uses_rt & (i_exe_dest == i_id_rt);
    // $zero is never actually written, so it cannot create a dependency.
    assign o_lu     = i_exe_mem_read & (i_exe_dest != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stalls, branch
// flushes, multi-cycle mult/div hold in EXE and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_md_start,
    input  logic                   exe_mem_read,
    input  logic [4:0]             exe_dest,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idexe_bubble,
    output logic                   idexe_hold,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(MD_LAT);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_md_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic                   w_lu;

    load_use_detect u_lud (
        .i_exe_mem_read (exe_mem_read),
        .i_exe_dest     (exe_dest),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rt   (id_uses_rt),
        .o_lu           (w_lu)
    );

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        idexe_hold   = 1'b0;
        md_busy      = 1'b0;
        if (!rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
        end else if (r_state == MD_WAIT) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idexe_hold = 1'b1;
            md_busy    = 1'b1;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else if (w_lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= RUN;
            r_md_cnt       <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            case (r_state)
                RUN: begin
                    // A mult/div only launches when nothing of higher priority claims the cycle.
                    if (!branch_taken && !w_lu && id_md_start) begin
                        r_state  <= MD_WAIT;
                        r_md_cnt <= CNT_W'(MD_LAT - 1);
                    end
                end
                MD_WAIT: begin
                    r_md_cnt <= r_md_cnt - CNT_W'(1);
                    if (r_md_cnt == CNT_W'(1))
                        r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=4, STALL_CNT_W=4) with
// hand-computed expectations and continuous invariant checks.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       id_md_start = 1'b0;
    logic       exe_mem_read = 1'b0;
    logic [4:0] exe_dest = '0;
    logic       branch_taken = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idexe_bubble, idexe_hold, md_busy;
    logic [3:0] stall_cycles;

    int n_chk = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MD_LAT(4), .STALL_CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_md_start  (id_md_start),
        .exe_mem_read (exe_mem_read),
        .exe_dest     (exe_dest),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idexe_bubble (idexe_bubble),
        .idexe_hold   (idexe_hold),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_md_start = 1'b0;
        exe_mem_read = 1'b0; exe_dest = '0; branch_taken = 1'b0;
    endtask

    // Invariants: hold and bubble exclusive, flush implies PC advance, busy tracks hold.
    always @(negedge clk) begin
        chk("inv_hold_bubble", 32'(idexe_hold & idexe_bubble), 32'd0);
        chk("inv_flush_pc",    32'(ifid_flush & ~pc_write),    32'd0);
        chk("inv_busy_hold",   32'(md_busy),                   32'(idexe_hold));
    end

    initial begin
        idle();
        #2;
        chk("rst_pc_write",   32'(pc_write),     32'd0);
        chk("rst_ifid_write", 32'(ifid_write),   32'd0);
        chk("rst_flush",      32'(ifid_flush),   32'd0);
        chk("rst_bubble",     32'(idexe_bubble), 32'd1);
        chk("rst_hold",       32'(idexe_hold),   32'd0);
        chk("rst_busy",       32'(md_busy),      32'd0);
        chk("rst_stall",      32'(stall_cycles), 32'd0);
        #10 rst = 1'b1;
        tick();
        chk("idle_pc_write", 32'(pc_write), 32'd1);
        chk("idle_stall",    32'(stall_cycles), 32'd0);

        // 1. load-use on rs
        exe_mem_read = 1'b1; exe_dest = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_rs_pc_write",   32'(pc_write),     32'd0);
        chk("lu_rs_ifid_write", 32'(ifid_write),   32'd0);
        chk("lu_rs_bubble",     32'(idexe_bubble), 32'd1);
        tick();
        idle();
        #1;
        chk("lu_rs_after_pc",     32'(pc_write),     32'd1);
        chk("lu_rs_after_bubble", 32'(idexe_bubble), 32'd0);
        chk("lu_rs_stall",        32'(stall_cycles), 32'd1);

        // 2. zero register and rt gating
        exe_mem_read = 1'b1; exe_dest = 5'd0; id_rs = 5'd0;
        #1 chk("lu_zero_pc", 32'(pc_write), 32'd1);
        exe_dest = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0;
        #1 chk("lu_rt_unused_pc", 32'(pc_write), 32'd1);
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_pc",     32'(pc_write),     32'd0);
        chk("lu_rt_bubble", 32'(idexe_bubble), 32'd1);
        tick();
        idle();
        #1 chk("lu_rt_stall", 32'(stall_cycles), 32'd2);

        // 3. mult/div occupancy, with a stray branch/lu ignored while waiting
        id_md_start = 1'b1;
        #1;
        chk("md_start_pc",   32'(pc_write), 32'd1);
        chk("md_start_busy", 32'(md_busy),  32'd0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                branch_taken = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd3; id_rs = 5'd3;
            end
            #1;
            chk("md_wait_busy",   32'(md_busy),      32'd1);
            chk("md_wait_hold",   32'(idexe_hold),   32'd1);
            chk("md_wait_pc",     32'(pc_write),     32'd0);
            chk("md_wait_bubble", 32'(idexe_bubble), 32'd0);
            chk("md_wait_flush",  32'(ifid_flush),   32'd0);
            tick();
            idle();
        end
        #1;
        chk("md_done_busy",  32'(md_busy),      32'd0);
        chk("md_done_pc",    32'(pc_write),     32'd1);
        chk("md_done_stall", 32'(stall_cycles), 32'd5);

        // 4. branch beats load-use and mult/div
        branch_taken = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd9; id_rs = 5'd9; id_md_start = 1'b1;
        #1;
        chk("br_pc",     32'(pc_write),     32'd1);
        chk("br_ifid_w", 32'(ifid_write),   32'd1);
        chk("br_flush",  32'(ifid_flush),   32'd1);
        chk("br_bubble", 32'(idexe_bubble), 32'd1);
        tick();
        idle();
        #1;
        chk("br_after_busy",  32'(md_busy),      32'd0);
        chk("br_after_pc",    32'(pc_write),     32'd1);
        chk("br_after_stall", 32'(stall_cycles), 32'd5);

        // 5. asynchronous reset while md_cnt==2
        id_md_start = 1'b1;
        tick();
        idle();
        tick();
        #1 chk("mid_busy_before", 32'(md_busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(md_busy),      32'd0);
        chk("mid_rst_bubble", 32'(idexe_bubble), 32'd1);
        chk("mid_rst_stall",  32'(stall_cycles), 32'd0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rel_busy", 32'(md_busy),  32'd0);
        chk("mid_rel_pc",   32'(pc_write), 32'd1);
        tick();
        chk("mid_rel_busy2", 32'(md_busy),      32'd0);
        chk("mid_rel_stall", 32'(stall_cycles), 32'd0);

        // 6. saturation with a held load-use
        exe_mem_read = 1'b1; exe_dest = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_14", 32'(stall_cycles), 32'd14);
        end
        chk("sat_20", 32'(stall_cycles), 32'd15);
        idle();
        tick();
        chk("sat_hold", 32'(stall_cycles), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS pipeline.
- Sequences the PC, the IF/ID register and the ID/EXE register.
- Detects load-use hazards, flushes on taken branches, and holds a multi-cycle mult/div in EXE for MD_LAT cycles.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
MD_LAT, 4, total EXE occupancy of a mult/div in cycles; legal range 2..16
STALL_CNT_W, 16, width of the stall_cycles performance counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_md_start  in  1  ID instruction is a mult/div
exe_mem_read  in  1  EXE instruction is a load (M-stage read control bit)
exe_dest  in  5  destination register of the EXE instruction
branch_taken  in  1  branch resolved taken in EXE this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear (inserts a nop)
idexe_bubble  out  1  forces the EXE/M/WB control inputs of ID/EXE to zero
idexe_hold  out  1  ID/EXE keeps its current contents
md_busy  out  1  mult/div occupying EXE
stall_cycles  out  STALL_CNT_W  count of cycles with pc_write=0, saturating

Behaviour:
- State: FSM {RUN, MD_WAIT}, down-counter md_cnt of width clog2(MD_LAT), and stall_cycles.
- While rst=0 (asynchronous):
  - state=RUN, md_cnt=0, stall_cycles=0.
  - Outputs forced to pc_write=0, ifid_write=0, ifid_flush=0, idexe_bubble=1, idexe_hold=0, md_busy=0.
- Load-use hazard, combinational: lu = exe_mem_read & (exe_dest!=0) & ((exe_dest==id_rs) | (id_uses_rt & exe_dest==id_rt)).
- Outputs are combinational from state and inputs. There are no registered outputs except stall_cycles.
- RUN, priority order:
  1. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idexe_bubble=1. lu and id_md_start are ignored. Stay in RUN.
  2. lu: pc_write=0, ifid_write=0, idexe_bubble=1. Lasts exactly one cycle, because the load moves to MEM. id_md_start is ignored this cycle. Stay in RUN.
  3. id_md_start: normal advance (pc_write=1, ifid_write=1, all others 0). Next state MD_WAIT, md_cnt <= MD_LAT-1.
  4. Otherwise: pc_write=1, ifid_write=1, all others 0.
- MD_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idexe_hold=1, md_busy=1, idexe_bubble=0, ifid_flush=0.
  - md_cnt decrements each cycle; when md_cnt==1, next state is RUN.
  - branch_taken, lu and id_md_start are ignored (EXE holds the mult/div, so no branch can resolve).
  - Net effect: md_busy is high for MD_LAT-1 consecutive cycles and the mult/div occupies EXE for MD_LAT cycles.
- stall_cycles increments on every clock edge where rst=1 and pc_write=0. It holds at 2^STALL_CNT_W-1 once reached; no wrap.
- Reset mid-operation:
  - Asserting rst in MD_WAIT immediately returns to RUN with md_cnt=0.
  - After release, the first edge behaves as RUN.
- Invariants (assert in bench):
  - idexe_hold and idexe_bubble are never both 1.
  - ifid_flush=1 implies pc_write=1.
  - md_busy equals (state==MD_WAIT).

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MD_WAIT};
  - REG_ZERO=5'd0;
  - the control-field widths WB=2, M=3, EXE=4, used by whoever applies idexe_bubble;
  - the M-field bit index of mem_read.
- One natural sub-module: load_use_detect, the combinational comparator producing lu. The FSM, counter and stall counter stay in the top module.

Test Plan:
1. Load-use on rs: exe_mem_read=1, exe_dest=5, id_rs=5 for one cycle -> that cycle pc_write=0, ifid_write=0, idexe_bubble=1; next cycle (exe_mem_read=0) normal advance; stall_cycles 0->1.
2. Zero register and rt gating:
   - exe_dest=0, id_rs=0, exe_mem_read=1 -> no stall.
   - exe_dest=7, id_rt=7, id_uses_rt=0 -> no stall.
   - same with id_uses_rt=1 -> one-cycle stall.
3. Mult/div, MD_LAT=4: id_md_start=1 in RUN -> next 3 cycles md_busy=1, idexe_hold=1, pc_write=0; 4th cycle back in RUN with pc_write=1; stall_cycles +3.
4. Priority: branch_taken=1 together with lu=1 and id_md_start=1 -> pc_write=1, ifid_flush=1, idexe_bubble=1; state remains RUN; stall_cycles unchanged.
5. Reset mid-op: rst=0 asynchronously while in MD_WAIT with md_cnt=2 -> md_busy drops without a clock edge, idexe_bubble=1, stall_cycles=0; after release, RUN with pc_write=1.
6. Saturation, STALL_CNT_W=4: hold a load-use condition for 20 cycles -> stall_cycles reaches 15 and stays at 15.
